// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
// -----------------------------------------------------------------------------
// Parallel-to-serial pattern transmitter. A WIDTH-bit word is accepted over a
// valid/ready handshake and shifted out MSB-first on a_out, each bit held for
// HOLD_CYCLES clocks. A one-cycle done pulse follows the last bit.
//
// Optional feature (macro SERIAL_PARITY_BIT_EN): when defined, an even-parity
// bit (XOR of the captured data bits) is sent after the data bits, also for
// HOLD_CYCLES clocks. When undefined, no parity logic exists.
//
// Ports:
//   clk         system clock, rising-edge
//   reset_n     asynchronous active-low reset
//   load_valid  data_in is valid this cycle
//   load_ready  transmitter can accept a word (IDLE)
//   data_in     word to transmit
//   a_out       serial bit stream, MSB first (driven straight from a flop)
//   busy        word in flight (SEND or DONE)
//   done        one-cycle pulse after the last bit's hold period
//   zero_word   captured word was zero (valid while busy)
// -----------------------------------------------------------------------------
module serial_pattern_tx #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             a_out,
    output logic             busy,
    output logic             done,
    output logic             zero_word
);

    // The parity bit, when enabled, rides as an extra LSB of the shift
    // register so the same MSB tap serves data and parity alike.
`ifdef SERIAL_PARITY_BIT_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [BW-1:0] LAST_BIT  = BW'(SW - 1);
    localparam logic [7:0]    HOLD_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t          state_reg,    state_next;
    logic [SW-1:0]   shift_reg,    shift_next;
    logic [BW-1:0]   bit_cnt_reg,  bit_cnt_next;
    logic [7:0]      hold_cnt_reg, hold_cnt_next;
    logic            zero_reg,     zero_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
            zero_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            zero_reg     <= zero_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        hold_cnt_next = hold_cnt_reg;
        zero_next     = zero_reg;

        case (state_reg)
            ST_IDLE: begin
                if (load_valid) begin
`ifdef SERIAL_PARITY_BIT_EN
                    shift_next = {data_in, ^data_in};
`else
                    shift_next = data_in;
`endif
                    zero_next     = (data_in == '0);
                    bit_cnt_next  = '0;
                    hold_cnt_next = '0;
                    state_next    = ST_SEND;
                end
            end

            ST_SEND: begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    hold_cnt_next = '0;
                    // Zero-fill: after the final shift the register is empty,
                    // which is what holds a_out low in DONE and IDLE.
                    shift_next    = {shift_reg[SW-2:0], 1'b0};
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next = ST_DONE;
                    end else begin
                        // Held at LAST_BIT on the final bit so it never wraps.
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                end
            end

            ST_DONE: begin
                zero_next  = 1'b0;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign a_out      = shift_reg[SW-1];
    assign load_ready = (state_reg == ST_IDLE);
    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DONE);
    assign zero_word  = zero_reg;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx. Two lanes run side by side, one with
// HOLD_CYCLES=1 and one with HOLD_CYCLES=5. Each accepted word is expanded by a
// reference model into the per-cycle expected outputs (bit values repeated for
// the hold length, optional parity bit, then the done cycle) and queued; a
// negedge monitor pops one entry per busy cycle and compares.
module tb_serial_pattern_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic a;
        logic dn;
        logic zw;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam int H = (gi == 0) ? 1 : 5;

        logic       reset_n;
        logic       load_valid;
        logic       load_ready;
        logic [3:0] data_in;
        logic       a_out;
        logic       busy;
        logic       done;
        logic       zero_word;
        bit         fin = 1'b0;
        exp_t       q[$];

        serial_pattern_tx #(.WIDTH(4), .HOLD_CYCLES(H)) dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .load_valid (load_valid),
            .load_ready (load_ready),
            .data_in    (data_in),
            .a_out      (a_out),
            .busy       (busy),
            .done       (done),
            .zero_word  (zero_word)
        );

        // Reference model: what the line should show, cycle by cycle, for word d.
        task automatic push_word(input logic [3:0] d);
            logic zw;
            zw = (d == 4'd0);
            for (int i = 3; i >= 0; i--)
                for (int h = 0; h < H; h++)
                    q.push_back('{a: d[i], dn: 1'b0, zw: zw});
`ifdef SERIAL_PARITY_BIT_EN
            for (int h = 0; h < H; h++)
                q.push_back('{a: ^d, dn: 1'b0, zw: zw});
`endif
            q.push_back('{a: 1'b0, dn: 1'b1, zw: zw});
        endtask

        // Offer a word; with poke set, keep load_valid high with other data
        // for the whole flight to show it is ignored.
        task automatic send(input logic [3:0] d, input bit poke);
            int k;
            k = 0;
            while (!load_ready && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (!load_ready) chk($sformatf("L%0d ready_timeout", gi), {31'd0, load_ready}, 32'd1);
            load_valid = 1'b1;
            data_in    = d;
            push_word(d);
            @(negedge clk);
            load_valid = 1'b0;
            data_in    = 4'($urandom);
            if (poke) begin
                k = 0;
                while (busy && k < 200) begin
                    load_valid = 1'b1;
                    data_in    = ~d;
                    @(negedge clk);
                    k++;
                end
                load_valid = 1'b0;
            end
        endtask

        // Monitor
        always @(negedge clk) begin
            exp_t e;
            if (!reset_n) begin
                chk($sformatf("L%0d reset_outputs", gi),
                    {27'd0, a_out, load_ready, busy, done, zero_word}, 32'b01000);
            end else if (busy) begin
                if (q.size() == 0) begin
                    chk($sformatf("L%0d unexpected_busy", gi), {30'd0, busy, done}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("L%0d send_cycle a/done/zw/rdy", gi),
                        {28'd0, a_out, done, zero_word, load_ready},
                        {28'd0, e.a, e.dn, e.zw, 1'b0});
                end
            end else begin
                chk($sformatf("L%0d idle_outputs a/done/zw/rdy", gi),
                    {28'd0, a_out, done, zero_word, load_ready}, 32'b0001);
            end
        end

        // Driver
        initial begin
            reset_n    = 1'b0;
            load_valid = 1'b1;
            data_in    = 4'hF;
            repeat (3) @(negedge clk);
            load_valid = 1'b0;
            #2 reset_n = 1'b1;
            @(negedge clk);

            send(4'b1011, 1'b0);
            send(4'b1000, 1'b0);
            send(4'b0000, 1'b1);

            // Reset in the middle of a word: line drops at once, no done.
            send(4'b1111, 1'b0);
            repeat (2 * H) @(posedge clk);
            #2 reset_n = 1'b0;
            q.delete();
            #1 chk($sformatf("L%0d async_drop a/busy/done", gi), {29'd0, a_out, busy, done}, 32'd0);
            repeat (2) @(negedge clk);
            #2 reset_n = 1'b1;

            send(4'b0101, 1'b0);
            send(4'b0111, 1'b0);
            send(4'b0110, 1'b1);

            repeat (30) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send(4'($urandom), 1'($urandom_range(0, 1)));
            end

            for (int k = 0; k < 400 && q.size() != 0; k++) @(negedge clk);
            chk($sformatf("L%0d drain", gi), q.size(), 32'd0);
            @(negedge clk);
            fin = 1'b1;
        end
    end

    initial begin
        wait (g_lane[0].fin && g_lane[1].fin);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Parallel-to-serial pattern transmitter that drives the single-bit serial stimulus line consumed by the lab's 4-bit serial-in/parallel-out blocks.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first, one bit per HOLD_CYCLES clocks.
- Signals completion with a one-cycle done pulse.
- Flags zero words so the downstream zero-output check is predictable.

Parameters:
- WIDTH, 4, number of data bits per word (legal range 2..16).
- HOLD_CYCLES, 1, clocks each serial bit is held on a_out (legal range 1..255).

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset_n  input  1  asynchronous active-low reset
- load_valid  input  1  data_in is valid this cycle
- load_ready  output  1  transmitter can accept a word
- data_in  input  WIDTH  word to transmit
- a_out  output  1  serial bit stream, MSB first
- busy  output  1  word in flight (SEND or DONE state)
- done  output  1  one-cycle pulse after the last bit's hold period ends
- zero_word  output  1  word currently held has value 0 (valid while busy)

Behaviour:
- Reset (reset_n low, asynchronous, any state): state=IDLE, shift register=0, bit counter=0, hold counter=0, a_out=0, load_ready=1, busy=0, done=0, zero_word=0.
- States: IDLE, SEND, DONE.
- IDLE:
  - load_ready=1, busy=0, a_out=0.
  - Accept occurs when load_valid=1 and load_ready=1 at a rising edge.
  - On accept: capture data_in into the shift register, set zero_word=(data_in==0), clear both counters, go to SEND.
- SEND:
  - a_out = shift register MSB, registered output, so the first bit appears the cycle after accept (latency 1).
  - The hold counter counts 0..HOLD_CYCLES-1.
  - At terminal hold count: shift left by one, zero-fill, increment the bit counter.
  - After bit WIDTH-1 completes its hold (plus the parity bit when enabled), go to DONE.
  - load_ready=0, busy=1.
  - load_valid is ignored; there is no queuing.
- DONE:
  - Lasts exactly one cycle.
  - done=1, a_out=0, busy=1, load_ready=0.
  - Next state is IDLE, where zero_word clears.
- Timing: total a_out activity per word = WIDTH*HOLD_CYCLES cycles (+HOLD_CYCLES with parity). The done pulse immediately follows.
- Back-to-back words: the earliest next accept is the cycle after DONE, i.e. at least one idle cycle between words, with a_out=0.
- data_in changes while busy have no effect on the word in flight.
- Reset asserted mid-word: a_out drops to 0 immediately (asynchronous) and no done pulse is produced. After reset release, the next accept starts a clean word.
- Counter widths:
  - Bit counter: $clog2(WIDTH+1) bits.
  - Hold counter: 8 bits.
  - Neither counter wraps within a word.

Optional Feature:
- Macro: SERIAL_PARITY_BIT_EN.
- Defined:
  - After the WIDTH data bits, one extra bit equal to even parity (XOR of all captured data bits) is held on a_out for HOLD_CYCLES, then DONE.
  - For a zero word the parity bit is 0.
- Not defined:
  - No parity bit; DONE follows the last data bit directly.
  - No parity logic is synthesized.

Test Plan:
1. Reset: hold reset_n=0 for 3 cycles with load_valid=1, data_in=4'hF. Required: a_out=0, load_ready=1, busy=0, done=0 throughout; no accept.
2. Basic word: WIDTH=4, HOLD_CYCLES=1, load 4'b1011 in one cycle. Required:
   - a_out = 1,0,1,1 on the 4 following cycles.
   - done=1 on the 5th cycle.
   - load_ready=1 on the 6th.
3. Hold stretch: HOLD_CYCLES=5, load 4'b1000. Required:
   - a_out=1 for 5 cycles, then 0 for 15 cycles.
   - done on cycle 21 after accept.
4. Zero word plus busy-ignore: load 4'b0000. Required: zero_word=1 while busy and a_out=0 for all 4 bits. A second load_valid with 4'b1111 during SEND is ignored, verified by no second done pulse.
5. Mid-word reset: load 4'b1111, assert reset_n=0 after 2 bits. Required:
   - a_out=0 immediately and no done pulse.
   - After release, loading 4'b0101 yields a_out 0,1,0,1.
6. With SERIAL_PARITY_BIT_EN: load 4'b0111. Required: a_out = 0,1,1,1 then parity 1, and done on cycle 6 after accept. 4'b0110 gives parity 0.
